seq_shifter: RTL and testbench

Parametrised multi-cycle shift/rotate unit executing SLL, SRL, SRA and ROR for the execute stage. It generalises the fixed left-shift-by-2 branch-offset path to any data width, any shift amount and four modes. The shift amount is consumed STEP bits per cycle under a start/busy/done handshake, trading latency for area. The result is registered and held until the next accepted operation.

---
 rtl/seq_shifter.sv | 124 ++++++++++++
 tb/tb_seq_shifter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit (SLL, SRL, SRA, ROR).
// Consumes the shift amount up to STEP bits per cycle under a start/busy/done handshake.
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // STEP may equal WIDTH, which needs one bit more than the shift amount.
  localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W+1)'(STEP);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;

  logic [SHAMT_W-1:0] k;
  logic [SHAMT_W-1:0] neg_k;
  logic [WIDTH-1:0]   srl_val;
  logic [WIDTH-1:0]   fill_mask;
  logic [WIDTH-1:0]   shifted;

  always_comb begin
    if ({1'b0, rem_q} < STEP_L) begin
      k = rem_q;
    end else begin
      k = STEP_L[SHAMT_W-1:0];
    end
  end

  // Rotating right by k is a left shift by WIDTH-k, i.e. -k modulo WIDTH.
  assign neg_k     = SHAMT_W'(0) - k;
  assign srl_val   = work_q >> k;
  assign fill_mask = ~({WIDTH{1'b1}} >> k);

  always_comb begin
    case (op_q)
      OP_SLL:  shifted = work_q << k;
      OP_SRL:  shifted = srl_val;
      OP_SRA:  shifted = sign_q ? (srl_val | fill_mask) : srl_val;
      default: shifted = srl_val | (work_q << neg_k);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    rem_d    = rem_q;
    op_d     = op_q;
    sign_d   = sign_q;
    case (state_q)
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - k;
        if (rem_q == k) begin
          state_d  = DONE;
          result_d = shifted;
        end
      end
      default: begin
        // IDLE and DONE both accept; accepting in DONE gives back-to-back ops.
        state_d = IDLE;
        if (start) begin
          work_d = data_in;
          op_d   = op;
          sign_d = data_in[WIDTH-1];
          rem_d  = shamt;
          if (shamt == '0) begin
            state_d  = DONE;
            result_d = data_in;
          end else begin
            state_d = SHIFT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: two instances (STEP=1 and STEP=4) checked
// against an arithmetic reference model for result, latency and busy duration.
module tb_seq_shifter;

  logic        clk;
  logic        rst_n;
  logic        start1, start4;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;

  int n_checks = 0;
  int n_fail   = 0;

  seq_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy1), .done(done1), .result(result1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy4), .done(done4), .result(result4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single-shot reference: the final value of a shift by s, whatever the step size.
  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
    logic [63:0] dbl;
    case (o)
      2'd0:    return d << s;
      2'd1:    return d >> s;
      2'd2:    return 32'($signed(d) >>> s);
      default: begin
        dbl = {d, d} >> s;
        return dbl[31:0];
      end
    endcase
  endfunction

  task automatic set_start(input bit which, input logic v);
    if (which) start4 = v;
    else       start1 = v;
  endtask

  task automatic scramble();
    op      = 2'($urandom_range(0, 3));
    data_in = $urandom;
    shamt   = 5'($urandom_range(0, 31));
  endtask

  // which: 0 -> STEP=1 instance, 1 -> STEP=4 instance.
  // inject: cycle (1..n) at which a stray start is pulsed while busy, 0 for none.
  // b2b: start is raised in the current (DONE) cycle rather than the next one.
  task automatic run_op(input bit which, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp, input int inject,
                        input bit b2b, input bit post, input string tag);
    int step, n, cnt, busy_cnt;
    logic dn, bz;
    logic [31:0] res;
    step = which ? 4 : 1;
    n    = (int'(s) + step - 1) / step;
    if (!b2b) @(negedge clk);
    op = o; data_in = d; shamt = s;
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    scramble();
    cnt = 1; busy_cnt = 0;
    dn = which ? done4 : done1;
    while (!dn && cnt < 100) begin
      bz = which ? busy4 : busy1;
      if (bz) busy_cnt++;
      if (cnt == inject) scramble();
      set_start(which, cnt == inject);
      @(negedge clk);
      cnt++;
      dn = which ? done4 : done1;
    end
    set_start(which, 1'b0);
    res = which ? result4 : result1;
    check_eq({tag, "_done"}, 64'(dn), 64'd1);
    check_eq({tag, "_result"}, 64'(res), 64'(exp));
    check_eq({tag, "_latency"}, 64'(cnt), 64'(n + 1));
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n));
    $display("op%0d step=%0d op=%0d data=0x%08h shamt=%0d -> result=0x%08h latency=%0d busy=%0d",
             n_checks / 4, step, o, d, s, res, cnt, busy_cnt);
    if (post) begin
      @(negedge clk);
      dn  = which ? done4 : done1;
      res = which ? result4 : result1;
      check_eq({tag, "_done_pulse"}, 64'(dn), 64'd0);
      check_eq({tag, "_result_hold"}, 64'(res), 64'(exp));
    end
  endtask

  initial begin
    int done_seen, inj, n, step;
    logic [1:0] o;
    logic [31:0] d;
    logic [4:0] s;

    rst_n = 1'b1; start1 = 1'b0; start4 = 1'b0;
    op = '0; data_in = '0; shamt = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_busy1", 64'(busy1), 64'd0);
    check_eq("reset_done1", 64'(done1), 64'd0);
    check_eq("reset_result1", 64'(result1), 64'd0);
    check_eq("reset_busy4", 64'(busy4), 64'd0);
    check_eq("reset_done4", 64'(done4), 64'd0);
    check_eq("reset_result4", 64'(result4), 64'd0);
    rst_n = 1'b1;

    // Directed cases with hand-derived results.
    run_op(1'b0, 2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 0, 1'b0, 1'b1, "sll31");
    run_op(1'b0, 2'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 0, 1'b0, 1'b1, "sra4");
    run_op(1'b0, 2'd1, 32'h8000_0000, 5'd4,  32'h0800_0000, 0, 1'b0, 1'b1, "srl4");
    run_op(1'b0, 2'd3, 32'h0000_000F, 5'd4,  32'hF000_0000, 0, 1'b0, 1'b1, "ror4");
    run_op(1'b0, 2'd2, 32'h1234_5678, 5'd0,  32'h1234_5678, 0, 1'b0, 1'b1, "sra0");
    run_op(1'b1, 2'd0, 32'h0000_0003, 5'd5,  32'h0000_0060, 0, 1'b0, 1'b1, "step4_sll5");
    run_op(1'b1, 2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, "step4_sra31");
    run_op(1'b0, 2'd1, 32'hDEAD_BEEF, 5'd20, 32'h0000_0DEA, 5, 1'b0, 1'b1, "ignore_busy");
    run_op(1'b1, 2'd3, 32'h8765_4321, 5'd13, ref_op(2'd3, 32'h8765_4321, 5'd13), 2, 1'b0, 1'b1, "step4_ignore");

    // Back-to-back: second start raised in the DONE cycle of the first.
    run_op(1'b0, 2'd3, 32'h1234_5678, 5'd8,  32'h7812_3456, 0, 1'b0, 1'b0, "b2b_first");
    run_op(1'b0, 2'd0, 32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 0, 1'b1, 1'b1, "b2b_second");
    run_op(1'b1, 2'd1, 32'hF000_0000, 5'd9,  32'h0078_0000, 0, 1'b0, 1'b0, "b2b4_first");
    run_op(1'b1, 2'd2, 32'h8000_0000, 5'd0,  32'h8000_0000, 0, 1'b1, 1'b1, "b2b4_second");

    // Asynchronous reset in the middle of a SHIFT.
    @(negedge clk);
    op = 2'd1; data_in = 32'hFFFF_FFFF; shamt = 5'd25; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy1", 64'(busy1), 64'd0);
    check_eq("async_rst_done1", 64'(done1), 64'd0);
    check_eq("async_rst_result1", 64'(result1), 64'd0);
    check_eq("async_rst_result4", 64'(result4), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done1 || busy1) done_seen++;
    end
    check_eq("rst_no_done", 64'(done_seen), 64'd0);
    run_op(1'b0, 2'd0, 32'h0000_00A5, 5'd7, 32'h0000_5280, 0, 1'b0, 1'b1, "after_rst");

    // Randomised operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      o    = 2'($urandom_range(0, 3));
      d    = $urandom;
      s    = 5'($urandom_range(0, 31));
      step = (i % 2 == 1) ? 4 : 1;
      n    = (int'(s) + step - 1) / step;
      inj  = (n > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n)) : 0;
      run_op(i % 2 == 1, o, d, s, ref_op(o, d, s), inj, 1'b0, 1'b1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
